// File: rtl/mnist_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mnist_image_loader
//  Description : Host byte-stream frame receiver. Loads 16-bit pixels into the
//                image RAM, kicks the inference core, returns a result byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module mnist_image_loader #(
    parameter int unsigned NUM_PIXELS = 784,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned PIX_W      = 16,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int unsigned TIMEOUT    = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_wdata,
    output logic              net_start,
    input  logic              net_done,
    input  logic [15:0]       net_prediction,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy
);

    localparam int unsigned       TMR_W       = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [TMR_W-1:0]  c_tmr_last  = TMR_W'(TIMEOUT - 1);

    localparam logic [2:0] c_st_hunt  = 3'd0;
    localparam logic [2:0] c_st_lo    = 3'd1;
    localparam logic [2:0] c_st_hi    = 3'd2;
    localparam logic [2:0] c_st_start = 3'd3;
    localparam logic [2:0] c_st_wait  = 3'd4;
    localparam logic [2:0] c_st_resp  = 3'd5;

    logic [2:0]        state_q,     state_d;
    logic [ADDR_W-1:0] count_q,     count_d;
    logic [7:0]        lo_q,        lo_d;
    logic              ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [PIX_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic              net_start_q, net_start_d;
    logic [TMR_W-1:0]  timer_q,     timer_d;
    logic [7:0]        m_data_q,    m_data_d;
    logic              w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_st_hunt;
            count_q     <= '0;
            lo_q        <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            net_start_q <= 1'b0;
            timer_q     <= '0;
            m_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            lo_q        <= lo_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            net_start_q <= net_start_d;
            timer_q     <= timer_d;
            m_data_q    <= m_data_d;
        end
    end

    assign w_accept = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        lo_d        = lo_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        net_start_d = 1'b0;
        timer_d     = timer_q;
        m_data_d    = m_data_q;
        case (state_q)
            c_st_hunt: begin
                if (w_accept && (s_data == SYNC_BYTE)) begin
                    state_d = c_st_lo;
                    count_d = '0;
                end
            end
            c_st_lo: begin
                if (w_accept) begin
                    lo_d    = s_data;
                    state_d = c_st_hi;
                end
            end
            c_st_hi: begin
                if (w_accept) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = count_q;
                    ram_wdata_d = PIX_W'({s_data, lo_q});
                    if (count_q == c_last_addr) begin
                        state_d = c_st_start;
                    end else begin
                        count_d = count_q + 1'b1;
                        state_d = c_st_lo;
                    end
                end
            end
            // The final write is on the bus while here, so the start pulse lands one cycle later.
            c_st_start: begin
                net_start_d = 1'b1;
                timer_d     = '0;
                state_d     = c_st_wait;
            end
            c_st_wait: begin
                if (net_done) begin
                    m_data_d = (net_prediction <= 16'd9) ? {4'hD, net_prediction[3:0]} : 8'hEF;
                    state_d  = c_st_resp;
                end else if (timer_q == c_tmr_last) begin
                    m_data_d = 8'hEE;
                    state_d  = c_st_resp;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            c_st_resp: begin
                if (m_ready) begin
                    state_d = c_st_hunt;
                end
            end
            default: begin
                state_d = c_st_hunt;
            end
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b0;
        if (!rst) begin
            s_ready = (state_q == c_st_hunt) || (state_q == c_st_lo) || (state_q == c_st_hi);
            m_valid = (state_q == c_st_resp);
            busy    = (state_q != c_st_hunt);
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign net_start = net_start_q;
    assign m_data    = m_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mnist_image_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mnist_image_loader
//  Description : Directed self-checking bench with write/response scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mnist_image_loader;

    localparam int unsigned NPIX = 784;
    localparam int unsigned TMO  = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic        net_start;
    logic        net_done;
    logic [15:0] net_prediction;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int ns_count = 0;
    int cyc      = 0;

    logic [31:0] wq[$];
    logic [7:0]  rq[$];

    mnist_image_loader #(
        .NUM_PIXELS(NPIX),
        .ADDR_W    (10),
        .PIX_W     (16),
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .net_start     (net_start),
        .net_done      (net_done),
        .net_prediction(net_prediction),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_true(input string tag, input logic cond);
        checks++;
        assert (cond === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=1", tag, cond);
        end
    endtask

    // Scoreboard monitors: RAM writes, start pulses, response handshakes
    always @(negedge clk) begin
        if (!rst && ram_we) begin
            check_true("write_expected", wq.size() != 0);
            if (wq.size() != 0) check("ram_write", 32'({ram_addr, ram_wdata}), wq.pop_front());
        end
        if (!rst && net_start) begin
            ns_count <= ns_count + 1;
            check("writes_done_before_start", 32'(wq.size()), 32'd0);
            check("no_write_with_start", 32'(ram_we), 32'd0);
        end
        if (!rst && m_valid && m_ready) begin
            check_true("resp_expected", rq.size() != 0);
            if (rq.size() != 0) check("resp_byte", 32'(m_data), 32'(rq.pop_front()));
        end
    end

    // Entry and exit: 1 time unit after a rising edge
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int  g;
        bit  acc;
        int  n;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        s_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
        s_data  = b;
        s_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        do begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 1000);
        if (!acc) check_true("send_accept", acc);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_max, input int npix);
        send_byte(8'hA5, gap_max);
        check("busy_after_sync", 32'(busy), 32'd1);
        for (int i = 0; i < npix; i++) begin
            wq.push_back({6'd0, 10'(i), 16'(i)});
            send_byte(8'(i), gap_max);
            send_byte(8'(i >> 8), gap_max);
        end
    endtask

    task automatic finish_frame(input logic [15:0] pred, input int d, input int hold,
                                input logic [7:0] exp_b, input int exp_lat, input int hold_ready);
        bit found;
        int c0;
        found = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (net_start) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        check_true("net_start_seen", found);
        if (!found) return;
        c0 = cyc;
        @(posedge clk); #1;
        if (hold_ready > 0) m_ready = 1'b0;
        rq.push_back(exp_b);
        if (d >= 0) begin
            repeat (d) begin @(posedge clk); #1; end
            net_done       = 1'b1;
            net_prediction = pred;
            @(posedge clk); #1;
            if (hold == 1) net_done = 1'b0;
        end
        found = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (m_valid) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        check_true("resp_seen", found);
        check("resp_latency", 32'(cyc - c0), 32'(exp_lat));
        if (hold_ready > 0) begin
            for (int i = 0; i < hold_ready; i++) begin
                check("resp_hold_valid", 32'(m_valid), 32'd1);
                check("resp_hold_data", 32'(m_data), 32'(exp_b));
                @(posedge clk); #1;
                if (i < hold_ready - 1) @(negedge clk);
            end
            m_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        net_done = 1'b0;
        @(negedge clk);
        check("valid_drop", 32'(m_valid), 32'd0);
        check("idle_after_resp", 32'(busy), 32'd0);
        check("ready_after_resp", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_data = 8'h00; s_valid = 1'b0;
        net_done = 1'b0; net_prediction = 16'h0000; m_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("reset_s_ready", 32'(s_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_s_ready", 32'(s_ready), 32'd1);
        check("post_reset_ram_we", 32'(ram_we), 32'd0);
        check("post_reset_start", 32'(net_start), 32'd0);
        check("post_reset_m_valid", 32'(m_valid), 32'd0);
        check("post_reset_m_data", 32'(m_data), 32'd0);
        @(posedge clk); #1;

        // Junk bytes and a stray done pulse in HUNT are ignored
        net_done = 1'b1; net_prediction = 16'd4;
        @(posedge clk); #1;
        net_done = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        check("busy_after_junk", 32'(busy), 32'd0);

        // Back-to-back frame, prediction 7
        send_frame(0, NPIX);
        finish_frame(16'd7, 5, 1, 8'hD7, 7, 0);

        // Gapped frame, consumer stalls 20 cycles
        send_frame(3, NPIX);
        finish_frame(16'd7, 2, 1, 8'hD7, 4, 20);

        // No done: timeout
        send_frame(0, NPIX);
        finish_frame(16'd0, -1, 1, 8'hEE, TMO, 0);

        // Out-of-range prediction, done held several cycles
        send_frame(0, NPIX);
        finish_frame(16'd12, 3, 3, 8'hEF, 5, 0);

        // Done coincides with the timeout cycle
        send_frame(0, NPIX);
        finish_frame(16'd3, TMO - 2, 1, 8'hD3, TMO, 0);

        // Reset mid-frame, then a complete frame
        send_frame(0, 300);
        send_byte(8'h2C, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midframe_reset_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midframe_writes_drained", 32'(wq.size()), 32'd0);
        check("midframe_busy", 32'(busy), 32'd0);
        repeat (10) begin @(posedge clk); #1; end
        check("partial_no_start", 32'(ns_count), 32'd5);
        send_frame(0, NPIX);
        finish_frame(16'd9, 4, 1, 8'hD9, 6, 0);

        check("start_pulse_total", 32'(ns_count), 32'd6);
        check("write_queue_empty", 32'(wq.size()), 32'd0);
        check("resp_queue_empty", 32'(rq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
